multi_axis_step_generator: RTL and testbench
============================================

Name: multi_axis_step_generator

Overview:
Parametrised successor of the single-axis segment step generator. It drives NUM_AXES stepper channels from one motion segment stream. All logic runs on a single system clock, with a sample_tick enable replacing the separate step-sampling clock. A one-entry pending buffer accepts the next segment during the current one, so back-to-back segments execute with no gap. Each channel gets a direction output from the sign of its per-sample delta. The block sits between the segment FIFO and the motor driver pins.

Parameters:
NUM_AXES, 4, number of stepper channels.
ACC_WIDTH, 32, width of each per-axis position accumulator and delta field (two's-complement delta).
FRAC_BITS, 16, fractional bits of the accumulator; step_out of an axis is accumulator bit FRAC_BITS-1.
COUNT_WIDTH, 32, width of the segment sample count.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
sample_tick  input  1  single-cycle step-sample enable, one per step sample period.
seg_valid  input  1  segment offered by the upstream FIFO.
seg_ready  output  1  pending buffer empty; segment accepted when seg_valid && seg_ready at a clk edge.
seg_delta  input  NUM_AXES*ACC_WIDTH  per-axis signed delta per sample; axis i occupies [i*ACC_WIDTH +: ACC_WIDTH].
seg_count  input  COUNT_WIDTH  number of sample ticks the segment lasts.
step_out  output  NUM_AXES  registered step waveform per axis.
dir_out  output  NUM_AXES  registered direction per axis; 1 = negative delta.
is_busy  output  1  active segment running or pending segment held.
segment_done  output  1  one-cycle pulse when a segment finishes or is discarded.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pending empty, all accumulators=0, remaining=0.
  - step_out=0, dir_out=0, is_busy=0, segment_done=0.
  - seg_ready=1 (it is the inverse of the pending flag).
  - Reset mid-segment abandons both the active and pending segments immediately.
- Pending buffer:
  - Acceptance: on seg_valid && seg_ready, latch seg_delta and seg_count into the pending buffer and set pending_full. seg_ready drops the next cycle.
  - Zero count: a segment with seg_count==0 is accepted, then dropped when it reaches the load point. It produces a segment_done pulse, consumes no ticks and leaves step_out and dir_out unchanged.
- Load (pending -> active), performed at one clk edge:
  - remaining<=count.
  - For each axis: dir_out<=delta sign bit and mag<=|delta|. Magnitude of the most-negative delta saturates to 2^(ACC_WIDTH-1)-1.
  - Accumulators <=0.
  - pending_full<=0.
- States:
  - IDLE: if pending_full, load and go to RUN on the next edge. This gives 1 clk latency from acceptance to RUN. sample_tick is ignored in IDLE.
  - RUN, on sample_tick: every accumulator += mag (wraps mod 2^ACC_WIDTH) and remaining -= 1. Without sample_tick, everything holds.
  - RUN, on sample_tick with remaining==1: assert segment_done next cycle.
    - If pending_full, load pending on that same edge and stay in RUN (zero-gap chaining).
    - Otherwise clear accumulators and go to IDLE.
- step_out[i] is a register equal to accumulator bit FRAC_BITS-1, updated on the same edge as the accumulator.
- is_busy = (state==RUN) || pending_full.
- Simultaneous events:
  - Acceptance into an empty pending buffer and the end-of-segment load on the same edge: the load takes the old pending contents only if pending_full was already set. A newly accepted segment waits one cycle.
  - sample_tick in the load cycle from IDLE is not applied to the new segment.

Optional Feature:
STEP_PHASE_CARRY_EN
- Defined: accumulators are not cleared on a chained load (RUN->RUN). The fractional phase carries across back-to-back segments, so no step is lost or doubled at a boundary. Loads from IDLE still clear.
- Not defined: accumulators clear on every load, as described above.

Test Plan:
- Reset then idle: after rst_n rises, seg_ready=1, is_busy=0, and all outputs stay 0 for 100 ticks.
- Single segment, axis0 delta=0x0000_4000, count=8, tick every 4 clk:
  - step_out[0] toggles on ticks 2, 4, 6 and 8 (0→1 at tick 2), giving 2 full step periods.
  - segment_done pulses once after tick 8, then the block returns to IDLE with the accumulator at 0.
- Negative delta, axis1 delta=-0x0000_8000, count=4: dir_out[1]=1 from the load edge, and step_out[1] toggles on every tick.
- Back-to-back: segment A count=3 then segment B count=2, both offered early:
  - B is accepted while A runs, and seg_ready=0 until B loads.
  - B loads on A's third tick edge, with no IDLE cycle between them.
  - Exactly 2 segment_done pulses in total.
- Zero count and saturation:
  - count=0 segment gives segment_done with no step_out change.
  - delta=0x8000_0000 with count=2 gives dir=1 and accumulator 0x7FFF_FFFF after the first tick.
- Reset mid-RUN with pending full: rst_n low for 1 clk gives all outputs 0 and seg_ready=1 immediately, and no segment_done pulse.

Source files
------------

// File: rtl/multi_axis_step_generator.sv
// Multi-axis DDA step generator: one segment stream drives NUM_AXES step/dir channels.
// Optional STEP_PHASE_CARRY_EN keeps accumulator phase across chained (RUN->RUN) loads.
module multi_axis_step_generator #(
  parameter int NUM_AXES    = 4,
  parameter int ACC_WIDTH   = 32,
  parameter int FRAC_BITS   = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sample_tick,
  input  logic                            seg_valid,
  output logic                            seg_ready,
  input  logic [NUM_AXES*ACC_WIDTH-1:0]   seg_delta,
  input  logic [COUNT_WIDTH-1:0]          seg_count,
  output logic [NUM_AXES-1:0]             step_out,
  output logic [NUM_AXES-1:0]             dir_out,
  output logic                            is_busy,
  output logic                            segment_done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [ACC_WIDTH-1:0] MOST_NEG = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] MAX_POS  = {1'b0, {(ACC_WIDTH-1){1'b1}}};

  logic [0:0]                    state_reg, state_next;
  logic                          pending_full_reg, pending_full_next;
  logic [NUM_AXES*ACC_WIDTH-1:0] pending_delta_reg;
  logic [COUNT_WIDTH-1:0]        pending_count_reg;
  logic [COUNT_WIDTH-1:0]        remaining_reg, remaining_next;
  logic                          segment_done_reg;

  logic accept, pending_zero, advance, last_tick;
  logic load_idle, load_chain, load, drop, clear_acc;

  assign accept       = seg_valid && !pending_full_reg;
  assign pending_zero = (pending_count_reg == '0);
  assign advance      = (state_reg == RUN) && sample_tick;
  assign last_tick    = advance && (remaining_reg == COUNT_WIDTH'(1));
  assign load_idle    = (state_reg == IDLE) && pending_full_reg && !pending_zero;
  assign drop         = (state_reg == IDLE) && pending_full_reg && pending_zero;
  // A zero-count segment is never chained; it is dropped from IDLE on the following edge.
  assign load_chain   = last_tick && pending_full_reg && !pending_zero;
  assign load         = load_idle || load_chain;

`ifdef STEP_PHASE_CARRY_EN
  assign clear_acc = load_idle || (last_tick && !load_chain);
`else
  assign clear_acc = load_idle || last_tick;
`endif

  always_comb begin
    state_next = state_reg;
    if (load)
      state_next = RUN;
    else if (last_tick)
      state_next = IDLE;
  end

  always_comb begin
    pending_full_next = pending_full_reg;
    if (load || drop)
      pending_full_next = 1'b0;
    else if (accept)
      pending_full_next = 1'b1;
  end

  always_comb begin
    remaining_next = remaining_reg;
    if (load)
      remaining_next = pending_count_reg;
    else if (advance)
      remaining_next = remaining_reg - COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      pending_full_reg  <= 1'b0;
      pending_delta_reg <= '0;
      pending_count_reg <= '0;
      remaining_reg     <= '0;
      segment_done_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pending_full_reg <= pending_full_next;
      remaining_reg    <= remaining_next;
      segment_done_reg <= last_tick || drop;
      if (accept) begin
        pending_delta_reg <= seg_delta;
        pending_count_reg <= seg_count;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_AXES; gi++) begin : g_axis
      logic [ACC_WIDTH-1:0] pend_delta;
      logic [ACC_WIDTH-1:0] pend_mag;
      logic [ACC_WIDTH-1:0] acc_reg, acc_next;
      logic [ACC_WIDTH-1:0] mag_reg;
      logic                 step_reg, dir_reg;

      assign pend_delta = pending_delta_reg[gi*ACC_WIDTH +: ACC_WIDTH];

      // The most-negative delta has no positive twin, so clamp it one below.
      always_comb begin
        pend_mag = pend_delta;
        if (pend_delta[ACC_WIDTH-1]) begin
          if (pend_delta == MOST_NEG)
            pend_mag = MAX_POS;
          else
            pend_mag = ACC_WIDTH'(0) - pend_delta;
        end
      end

      always_comb begin
        acc_next = acc_reg;
        if (clear_acc)
          acc_next = '0;
        else if (advance)
          acc_next = acc_reg + mag_reg;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg  <= '0;
          mag_reg  <= '0;
          step_reg <= 1'b0;
          dir_reg  <= 1'b0;
        end else begin
          acc_reg  <= acc_next;
          step_reg <= acc_next[FRAC_BITS-1];
          if (load) begin
            mag_reg <= pend_mag;
            dir_reg <= pend_delta[ACC_WIDTH-1];
          end
        end
      end

      assign step_out[gi] = step_reg;
      assign dir_out[gi]  = dir_reg;
    end
  endgenerate

  assign seg_ready    = !pending_full_reg;
  assign is_busy      = (state_reg == RUN) || pending_full_reg;
  assign segment_done = segment_done_reg;

endmodule

// File: tb/tb_multi_axis_step_generator.sv
// Scoreboard bench for multi_axis_step_generator (default build, phase carry disabled).
module tb_multi_axis_step_generator;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_tick = 1'b0;
  logic          seg_valid = 1'b0;
  logic          seg_ready;
  logic [N*AW-1:0] seg_delta = '0;
  logic [CW-1:0] seg_count = '0;
  logic [N-1:0]  step_out, dir_out;
  logic          is_busy, segment_done;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  typedef struct {
    string        tag;
    logic [N-1:0] step;
    logic [N-1:0] dir;
    logic         ready;
    logic         busy;
  } exp_t;

  exp_t tick_q[$];
  exp_t done_q[$];

  always #5 clk = ~clk;

  multi_axis_step_generator #(
    .NUM_AXES(N), .ACC_WIDTH(AW), .FRAC_BITS(16), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_delta(seg_delta), .seg_count(seg_count),
    .step_out(step_out), .dir_out(dir_out),
    .is_busy(is_busy), .segment_done(segment_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [N-1:0] st, input logic [N-1:0] dr,
                              input logic rdy, input logic bsy);
    exp_t e;
    e.tag = tag; e.step = st; e.dir = dr; e.ready = rdy; e.busy = bsy;
    return e;
  endfunction

  // Step bit after k ticks from a zero accumulator with magnitude m.
  function automatic logic step_bit(input longint m, input int k);
    longint p;
    p = m * longint'(k);
    return p[15];
  endfunction

  function automatic logic [N*AW-1:0] axis_delta(input int axis, input logic [AW-1:0] d);
    logic [N*AW-1:0] v;
    v = '0;
    v[axis*AW +: AW] = d;
    return v;
  endfunction

  // Monitor: pops one expectation per applied tick and one per segment_done pulse.
  always @(posedge clk) begin
    logic t;
    exp_t e;
    t = sample_tick;
    #1;
    if (segment_done) begin
      done_seen++;
      if (done_q.size() == 0) begin
        check("done_unexpected", 64'd1, 64'd0);
      end else begin
        e = done_q.pop_front();
        check({"done_", e.tag}, {seg_ready, is_busy, dir_out, step_out}, {e.ready, e.busy, e.dir, e.step});
      end
    end
    if (t && tick_q.size() > 0) begin
      e = tick_q.pop_front();
      check({"tick_", e.tag}, {seg_ready, is_busy, dir_out, step_out}, {e.ready, e.busy, e.dir, e.step});
    end
  end

  task automatic send_seg(input logic [N*AW-1:0] d, input logic [CW-1:0] c);
    int n;
    n = 0;
    @(negedge clk);
    seg_valid = 1'b1; seg_delta = d; seg_count = c;
    while (!seg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 64'd1, 64'd0);
    @(negedge clk);
    seg_valid = 1'b0;
  endtask

  // Called at a negedge; the tick is sampled at the following posedge.
  task automatic tick(input bit expect_it, input exp_t e, input int gap);
    sample_tick = 1'b1;
    if (expect_it) tick_q.push_back(e);
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  exp_t none;

  initial begin
    none = mk("none", '0, '0, 1'b1, 1'b0);
    #2;
    check("reset_outputs", {seg_ready, is_busy, segment_done, dir_out, step_out}, {1'b1, 1'b0, 1'b0, 4'h0, 4'h0});
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: ticks are ignored and nothing moves.
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, none, 2);
      check("idle", {seg_ready, is_busy, segment_done, dir_out, step_out}, {1'b1, 1'b0, 1'b0, 4'h0, 4'h0});
    end

    // Single segment, tick every 4 clk; the tick on the load edge is ignored.
    done_q.push_back(mk("single", 4'h0, 4'h0, 1'b1, 1'b0));
    send_seg(axis_delta(0, 32'h0000_4000), 8);
    tick(1'b0, none, 4);
    for (int k = 1; k <= 8; k++)
      tick(1'b1, mk("single", {3'b000, (k < 8) ? step_bit(64'h4000, k) : 1'b0}, 4'h0, 1'b1, k < 8), 4);
    repeat (4) @(negedge clk);
    check("single_idle", {seg_ready, is_busy, step_out}, {1'b1, 1'b0, 4'h0});

    // Negative delta on axis 1.
    done_q.push_back(mk("neg", 4'h0, 4'b0010, 1'b1, 1'b0));
    send_seg(axis_delta(1, 32'hFFFF_8000), 4);
    @(negedge clk);
    check("neg_dir_load", dir_out, 4'b0010);
    for (int k = 1; k <= 4; k++)
      tick(1'b1, mk("neg", {2'b00, (k < 4) ? step_bit(64'h8000, k) : 1'b0, 1'b0}, 4'b0010, 1'b1, k < 4), 2);

    // Zero count: done pulse, direction and step untouched.
    done_q.push_back(mk("zero", 4'h0, 4'b0010, 1'b1, 1'b0));
    send_seg(axis_delta(1, 32'h0000_4000), 0);
    repeat (2) @(negedge clk);
    tick(1'b0, none, 2);
    check("zero_hold", {is_busy, dir_out, step_out}, {1'b0, 4'b0010, 4'h0});

    // Back-to-back: B accepted while A runs, chained on A's last tick.
    done_q.push_back(mk("chainA", 4'h0, 4'h0, 1'b1, 1'b1));
    done_q.push_back(mk("chainB", 4'h0, 4'h0, 1'b1, 1'b0));
    send_seg(axis_delta(2, 32'hFFFF_8000), 3);
    fork
      send_seg(axis_delta(0, 32'h0000_C000), 2);
      begin
        repeat (3) @(negedge clk);
        check("b2b_ready_low", {seg_ready, is_busy}, {1'b0, 1'b1});
        tick(1'b1, mk("A1", 4'b0100, 4'b0100, 1'b0, 1'b1), 2);
        tick(1'b1, mk("A2", 4'b0000, 4'b0100, 1'b0, 1'b1), 2);
        tick(1'b1, mk("A3", 4'b0000, 4'b0000, 1'b1, 1'b1), 2);
        tick(1'b1, mk("B1", 4'b0001, 4'b0000, 1'b1, 1'b1), 2);
        tick(1'b1, mk("B2", 4'b0000, 4'b0000, 1'b1, 1'b0), 2);
      end
    join

    // Saturation of the most-negative delta.
    done_q.push_back(mk("sat", 4'h0, 4'b0001, 1'b1, 1'b0));
    send_seg(axis_delta(0, 32'h8000_0000), 2);
    @(negedge clk);
    check("sat_dir", dir_out, 4'b0001);
    tick(1'b1, mk("sat1", 4'b0001, 4'b0001, 1'b1, 1'b1), 2);
    tick(1'b1, mk("sat2", 4'b0000, 4'b0001, 1'b1, 1'b0), 2);

    // Reset mid-RUN with a pending segment held.
    send_seg(axis_delta(0, 32'hFFFF_C000), 10);
    send_seg(axis_delta(3, 32'h0000_4000), 5);
    tick(1'b1, mk("rst1", 4'b0000, 4'b0001, 1'b0, 1'b1), 2);
    tick(1'b1, mk("rst2", 4'b0001, 4'b0001, 1'b0, 1'b1), 2);
    rst_n = 1'b0;
    #1;
    check("reset_mid_run", {seg_ready, is_busy, segment_done, dir_out, step_out}, {1'b1, 1'b0, 1'b0, 4'h0, 4'h0});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("after_reset", {seg_ready, is_busy, dir_out, step_out}, {1'b1, 1'b0, 4'h0, 4'h0});

    check("tick_q_empty", tick_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    check("done_count", done_seen, 6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
